mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Shares one W-bit output channel, a registered N:1 mux, between N_IN requesters using valid/ready handshakes.
- Arbitrates each cycle the output register can accept data, then registers the winner's data and index.
- Sits between producer blocks and a single shared consumer; it is the sequencing controller for the mux datapath.

Parameters:
N_IN, 4, number of requesters (>=2)
W, 8, data width per requester
SEL_W, $clog2(N_IN), width of the grant index (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  N_IN  requester i has data
in_data  input  N_IN*W  requester i data at bits [i*W +: W]
in_ready  output  N_IN  one-hot or zero; requester i transfers when in_valid[i] && in_ready[i]
out_valid  output  1  output register holds data
out_data  output  W  registered data of the accepted requester
out_sel  output  SEL_W  index of the requester that produced out_data
out_ready  input  1  consumer accepts when out_valid && out_ready

Behaviour:
- Reset, when rst_n=0 at a clk edge: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0, state=EMPTY. in_ready is combinational and is 0 while rst_n=0.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- accept = (state==EMPTY) || out_ready.
- Arbitration (combinational):
  - If accept and any in_valid, winner g is the first i with in_valid[i]=1, scanning ptr, ptr+1, ... modulo N_IN.
  - in_ready[g]=1; all other in_ready bits are 0.
  - If no in_valid, or accept=0, in_ready is all 0.
  - in_ready never depends on in_data.
- Transfer at a clk edge with accept && |in_valid:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
  - ptr <= (g==N_IN-1) ? 0 : g+1, wrapping.
  - State becomes FULL.
- Accept with no in_valid: out_valid <= 0, state becomes EMPTY. out_data and out_sel keep their old values (don't-care while out_valid=0).
- FULL && !out_ready: out_data, out_sel and out_valid are held stable; ptr is unchanged.
- Latency and throughput:
  - Input handshake to out_valid is 1 cycle.
  - Back-to-back transfers at 1 per cycle while out_ready=1.
  - No bubble on simultaneous drain and refill.
- Fairness: under continuous requests from all N_IN requesters with out_ready=1, grants cycle 0,1,...,N_IN-1,0.
- A requester that drops in_valid while not granted is simply skipped; no state is kept for it.
- Reset mid-transfer discards the held word; after rst_n rises, the first grant goes to the lowest valid index (ptr=0).
- At most one in_ready bit is high in any cycle.

Optional Feature:
- Macro: MUX_RR_ARBITER_RR_EN.
- Defined: round-robin arbitration with the rotating ptr, as specified above.
- Undefined: fixed priority, where the lowest index with in_valid=1 always wins. ptr is not implemented; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_sel=0, out_data=0.
- Single requester: in_valid=0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=0100 in that cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
- Round-robin: in_valid=1111 constant, data i = 8'h10+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 with matching out_data and no idle cycles. Without MUX_RR_ARBITER_RR_EN the sequence is 0,0,0,0.
- Backpressure: out_valid=1 with out_data=8'h3C and out_ready=0 for 3 cycles while in_valid=0011 -> out_data stays 8'h3C and in_ready=0000. Raising out_ready gives in_ready one-hot on the next round-robin winner in the same cycle.
- Drain: out_valid=1, out_ready=1, in_valid=0000 -> next cycle out_valid=0, state EMPTY.
- Reset mid-hold: FULL with out_sel=3 and out_ready=0, pulse rst_n=0 for 1 cycle -> out_valid=0. With in_valid=1001 the first grant after reset is index 0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - registered N:1 mux with valid/ready arbitration; define MUX_RR_ARBITER_RR_EN for round-robin, else fixed priority
module mux_rr_arbiter #(
  parameter int N_IN = 4,
  parameter int W = 8,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   in_valid,
  input  logic [N_IN*W-1:0] in_data,
  output logic [N_IN-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_data;
  logic [SEL_W-1:0]   r_sel;
  logic               w_accept;
  logic               w_found;
  logic [SEL_W-1:0]   w_gidx;
  logic [SEL_W-1:0]   w_cand;
  logic [SEL_W-1:0]   w_start;
  int                 w_idx;

`ifdef MUX_RR_ARBITER_RR_EN
  logic [SEL_W-1:0]   r_ptr;
  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif

  // The output register can take a new word when empty or when it is being drained this cycle
  assign w_accept = (r_state == EMPTY) || out_ready;

  // Scan requesters starting at the priority origin; first valid one wins
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    w_idx   = 0;
    for (int k = 0; k < N_IN; k++) begin
      w_idx  = (int'(w_start) + k) % N_IN;
      w_cand = SEL_W'(w_idx);
      if (!w_found && in_valid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  // Grant is one-hot on the winner, suppressed during reset or when the register cannot accept
  always_comb begin
    in_ready = '0;
    if (rst_n && w_accept && w_found) begin
      in_ready[w_gidx] = 1'b1;
    end
  end

  // Next state: a transfer fills the register, an accept with nothing offered empties it
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_found ? FULL : EMPTY;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the winner's data and index; held while full and stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sel  <= '0;
    end else if (w_accept && w_found) begin
      r_data <= in_data[int'(w_gidx)*W +: W];
      r_sel  <= w_gidx;
    end
  end

`ifdef MUX_RR_ARBITER_RR_EN
  // Rotate priority to just past the last winner so every requester gets a turn
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept && w_found) begin
      r_ptr <= (int'(w_gidx) == N_IN - 1) ? '0 : w_gidx + 1'b1;
    end
  end
`endif

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_checks;
  int n_fail;

  mux_rr_arbiter #(.N_IN(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'h13_12_11_10;
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d expected 0", out_sel); end
    n_checks++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    in_valid = 4'b0000;
    rst_n    = 1'b1;
  endtask

  task automatic test_single();
    in_valid        = 4'b0100;
    in_data[23:16]  = 8'hA5;
    out_ready       = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_in_ready: got %b expected 0100", in_ready); end
    tick();
    in_valid = 4'b0000;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
    n_checks++;
    if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_out_data: got %h expected a5", out_data); end
    n_checks++;
    if (out_sel !== 2'd2) begin n_fail++; $display("FAIL single_out_sel: got %0d expected 2", out_sel); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel;
    logic [1:0] nxt_sel;
    logic [3:0] exp_rdy;
    do_reset();
    in_data   = 32'h13_12_11_10;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef MUX_RR_ARBITER_RR_EN
      exp_sel = 2'(k % 4);
      nxt_sel = 2'((k + 1) % 4);
`else
      exp_sel = 2'd0;
      nxt_sel = 2'd0;
`endif
      exp_rdy = 4'b0001 << nxt_sel;
      tick();
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_out_valid[%0d]: got %b expected 1", k, out_valid); end
      n_checks++;
      if (out_sel !== exp_sel) begin n_fail++; $display("FAIL rr_out_sel[%0d]: got %0d expected %0d", k, out_sel, exp_sel); end
      n_checks++;
      if (out_data !== 8'h10 + 8'(exp_sel)) begin n_fail++; $display("FAIL rr_out_data[%0d]: got %h expected %h", k, out_data, 8'h10 + 8'(exp_sel)); end
      n_checks++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy); end
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rdy;
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
    do_reset();
    in_data[7:0]  = 8'h3C;
    in_data[15:8] = 8'h5A;
    in_valid      = 4'b0001;
    out_ready     = 1'b0;
    tick();
    in_valid = 4'b0011;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready_hold: got %b expected 0000", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_data !== 8'h3C) begin n_fail++; $display("FAIL bp_out_data[%0d]: got %h expected 3c", k, out_data); end
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", k, out_valid); end
      n_checks++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", k, in_ready); end
    end
`ifdef MUX_RR_ARBITER_RR_EN
    exp_rdy  = 4'b0010;
    exp_sel  = 2'd1;
    exp_data = 8'h5A;
`else
    exp_rdy  = 4'b0001;
    exp_sel  = 2'd0;
    exp_data = 8'h3C;
`endif
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected %b", in_ready, exp_rdy); end
    tick();
    in_valid = 4'b0000;
    n_checks++;
    if (out_sel !== exp_sel) begin n_fail++; $display("FAIL bp_release_out_sel: got %0d expected %0d", out_sel, exp_sel); end
    n_checks++;
    if (out_data !== exp_data) begin n_fail++; $display("FAIL bp_release_out_data: got %h expected %h", out_data, exp_data); end
  endtask

  task automatic test_drain();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_pre_valid: got %b expected 1", out_valid); end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL drain_in_ready: got %b expected 0000", in_ready); end
  endtask

  task automatic test_reset_mid_hold();
    in_data[31:24] = 8'hC3;
    in_valid       = 4'b1000;
    out_ready      = 1'b0;
    tick();
    in_valid = 4'b0000;
    n_checks++;
    if (out_sel !== 2'd3) begin n_fail++; $display("FAIL rmh_out_sel: got %0d expected 3", out_sel); end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmh_full: got %b expected 1", out_valid); end
    rst_n    = 1'b0;
    in_valid = 4'b1001;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmh_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL rmh_in_ready_rst: got %b expected 0000", in_ready); end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rmh_in_ready: got %b expected 0001", in_ready); end
    tick();
    in_valid = 4'b0000;
    n_checks++;
    if (out_sel !== 2'd0) begin n_fail++; $display("FAIL rmh_first_sel: got %0d expected 0", out_sel); end
    n_checks++;
    if (out_data !== 8'h3C) begin n_fail++; $display("FAIL rmh_first_data: got %h expected 3c", out_data); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
